muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the MUL/DIV/DIVU/MFHI/MFLO group that decode identifies.
- Owns the HI/LO registers, runs an iterative restoring divider and a fixed-latency multiplier, and stalls issue while the unit is occupied.
- Sits beside the execute ALU and takes operands after register read.
- Writeback receives rd results through a valid pulse.

Parameters:
- DATA_W, 32, operand/result/HI/LO width.
- DIV_CYCLES, 32, divider iterations (one quotient bit each); must equal DATA_W.
- MUL_CYCLES, 4, cycles spent in MUL state (models pipelined multiplier), >=1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue request; held by requester until accepted.
- op  in  3  000 none, 001 MUL, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO; 11x reserved.
- src_a  in  DATA_W  rs value (dividend / multiplicand).
- src_b  in  DATA_W  rt value (divisor / multiplier).
- stall  out  1  combinational: start && busy.
- busy  out  1  state != IDLE.
- result  out  DATA_W  rd write data (MUL low word, HI or LO).
- result_valid  out  1  one-cycle pulse, result valid for writeback.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- div_zero  out  1  sticky: last DIV/DIVU had divisor 0; cleared by next accepted DIV/DIVU.

Behaviour:
- Reset, and every cycle rst is high (including mid-operation): state IDLE, busy 0, result_valid 0, result 0, hi 0, lo 0, div_zero 0. In-flight op discarded; no result_valid pulse is produced for it.
- States: IDLE, MUL, DIV_RUN, DIV_FIX.
- Accept: start && state==IDLE && op valid (001-101) at cycle T. op 000 or 11x with start is ignored, with no state change.
- Requests arriving when not IDLE are not accepted. stall stays high while start is held. The requester holds op/src stable until stall falls.
- MFHI/MFLO: no state change. result <= hi/lo at edge ending T; result_valid high in T+1. Busy stays 0.
- MUL: operands latched at T. State MUL for cycles T+1..T+MUL_CYCLES, then IDLE. result = low DATA_W bits of the signed product, with result_valid high in T+MUL_CYCLES+1. HI/LO unchanged.
- DIV/DIVU accept:
  - Latch magnitudes (two's-complement absolute value for DIV; raw for DIVU) and the result signs.
  - Clear div_zero, or set it if src_b==0.
  - Counter <= DIV_CYCLES.
- DIV_RUN: occupies T+1..T+DIV_CYCLES. Each cycle shifts {rem,quot} left by 1, subtracts the divisor when rem >= divisor, and sets the quotient bit.
- DIV_FIX (cycle T+DIV_CYCLES+1):
  - Applies signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Writes lo=quotient, hi=remainder at the edge ending FIX.
  - Busy falls in T+DIV_CYCLES+2. No result_valid for DIV/DIVU.
- Divide by zero: lo=all ones, hi=dividend (original signed value), div_zero=1. Latency is unchanged unless the feature below is enabled.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0, no flag.
- Accept from IDLE is possible on the first cycle busy is 0. A request stalled behind a DIV is accepted in T+DIV_CYCLES+2; an MFLO issued then sees the new lo.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, a DIV/DIVU whose divisor is 0, or whose divisor magnitude > dividend magnitude, skips DIV_RUN and enters DIV_FIX at T+1.
  - Divisor 0: same hi/lo/div_zero results as without the feature.
  - Divisor larger: quotient 0, remainder = dividend.
  - Busy spans exactly 1 cycle.
- When undefined, every division takes DIV_CYCLES+1 busy cycles.

Test Plan:
- DIVU 100/7 -> busy high exactly 33 cycles; then lo=14, hi=2, div_zero=0, no result_valid.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- MUL 0x00010003 * 0x00000002 (hi=0x11, lo=0x22 preloaded) -> result_valid pulse at T+5 with result=0x00020006; hi/lo still 0x11/0x22.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1. Follow with DIVU 9/3 -> div_zero=0, lo=3, hi=0.
- MFLO held with start during DIVU 100/7 -> stall high every cycle busy=1; accepted in the first cycle busy=0; result=14 one cycle later.
- rst pulsed at cycle T+10 of a DIV -> next cycle busy=0, hi=lo=0, no result_valid. A subsequent DIVU 8/2 gives lo=4. With MULDIV_EARLY_OUT_EN, DIVU 3/8 -> busy 1 cycle, lo=0, hi=3.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between decode/execute and the MUL/DIV sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              stall;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;

    modport master (
        output start, op, src_a, src_b,
        input  stall, busy, result, result_valid, hi, lo, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output stall, busy, result, result_valid, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// MUL/DIV/DIVU/MFHI/MFLO sequencer: owns HI/LO, fixed-latency multiply,
// iterative restoring divide, stalls issue while occupied.
// Optional: define MULDIV_EARLY_OUT_EN to let trivial divisions (divisor 0 or
// divisor magnitude > dividend magnitude) skip the iteration phase.
module muldiv_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV_RUN, DIV_FIX} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] dividend;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] result_r;
    logic              result_valid_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              div_zero_r;

    logic              op_ok;
    logic              accept;
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              early;
    logic [DATA_W:0]   rem_sh;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_new;
    logic [DATA_W-1:0] quot_new;
    logic [DATA_W-1:0] q_fin;
    logic [DATA_W-1:0] r_fin;
    logic [DATA_W-1:0] product;

    // Issue decode and operand conditioning
    assign op_ok  = (bus.op != 3'b000) && (bus.op <= OP_MFLO);
    assign accept = bus.start && (state == IDLE) && op_ok;
    assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign a_neg  = (bus.op == OP_DIV) && bus.src_a[DATA_W-1];
    assign b_neg  = (bus.op == OP_DIV) && bus.src_b[DATA_W-1];
    assign a_mag  = a_neg ? (~bus.src_a + DATA_W'(1)) : bus.src_a;
    assign b_mag  = b_neg ? (~bus.src_b + DATA_W'(1)) : bus.src_b;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (bus.src_b == '0) || (b_mag > a_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring-division step on {rem, quot}
    assign rem_sh   = {rem, quot[DATA_W-1]};
    assign rem_ge   = rem_sh >= {1'b0, opb};
    assign rem_new  = rem_ge ? DATA_W'(rem_sh - {1'b0, opb}) : rem_sh[DATA_W-1:0];
    assign quot_new = {quot[DATA_W-2:0], rem_ge};

    // Sign fix-up; low word of a product is sign-agnostic
    assign q_fin   = neg_q ? (~quot + DATA_W'(1)) : quot;
    assign r_fin   = neg_r ? (~rem + DATA_W'(1)) : rem;
    assign product = mul_a * opb;

    assign bus.busy         = (state != IDLE);
    assign bus.stall        = bus.start && (state != IDLE);
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.hi           = hi_r;
    assign bus.lo           = lo_r;
    assign bus.div_zero     = div_zero_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) state_next = MUL;
                    else if (is_div)      state_next = early ? DIV_FIX : DIV_RUN;
                end
            end
            MUL:     if (cnt == CNT_W'(1)) state_next = IDLE;
            DIV_RUN: if (cnt == CNT_W'(1)) state_next = DIV_FIX;
            DIV_FIX: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO and result writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            mul_a          <= '0;
            opb            <= '0;
            rem            <= '0;
            quot           <= '0;
            dividend       <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            hi_r           <= '0;
            lo_r           <= '0;
            div_zero_r     <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MFHI: begin
                                result_r       <= hi_r;
                                result_valid_r <= 1'b1;
                            end
                            OP_MFLO: begin
                                result_r       <= lo_r;
                                result_valid_r <= 1'b1;
                            end
                            OP_MUL: begin
                                mul_a <= bus.src_a;
                                opb   <= bus.src_b;
                                cnt   <= CNT_W'(MUL_CYCLES);
                            end
                            default: begin
                                opb        <= b_mag;
                                quot       <= early ? '0 : a_mag;
                                rem        <= early ? a_mag : '0;
                                dividend   <= bus.src_a;
                                neg_q      <= a_neg ^ b_neg;
                                neg_r      <= a_neg;
                                div_zero_r <= (bus.src_b == '0);
                                cnt        <= CNT_W'(DIV_CYCLES);
                            end
                        endcase
                    end
                end
                MUL: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_r       <= product;
                        result_valid_r <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    rem  <= rem_new;
                    quot <= quot_new;
                    cnt  <= cnt - CNT_W'(1);
                end
                DIV_FIX: begin
                    lo_r <= div_zero_r ? '1 : q_fin;
                    hi_r <= div_zero_r ? dividend : r_fin;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MFLO = 3'b101;

    localparam int DIV_BUSY = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_BUSY = 1;
`else
    localparam int EARLY_BUSY = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.DATA_W(DATA_W)) bus ();

    muldiv_sequencer #(
        .DATA_W    (DATA_W),
        .DIV_CYCLES(32),
        .MUL_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle T+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.op    = OP_NONE;
    endtask

    // Run one division to completion and check HI/LO/flag/latency.
    task automatic div_case(input string tag, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                            input logic exp_dz, input int exp_busy);
        int busy_n = 0;
        int rv_n   = 0;
        issue(o, a, b);
        while (bus.busy && busy_n < 200) begin
            busy_n++;
            if (bus.result_valid) rv_n++;
            tick();
        end
        if (bus.result_valid) rv_n++;
        check({tag, "_busy"}, busy_n, exp_busy);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_dz"}, bus.div_zero, exp_dz);
        check({tag, "_no_rv"}, rv_n, 0);
    endtask

    initial begin
        int n;
        int bad;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.src_a = '0;
        bus.src_b = '0;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_dz", bus.div_zero, 0);
        rst = 1'b0;
        tick();

        // Ignored opcodes
        issue(OP_NONE, 32'd1, 32'd1);
        check("op0_busy", bus.busy, 0);
        check("op0_rv", bus.result_valid, 0);
        issue(3'b110, 32'd1, 32'd1);
        check("op6_busy", bus.busy, 0);
        issue(3'b111, 32'd1, 32'd1);
        check("op7_rv", bus.result_valid, 0);

        div_case("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, DIV_BUSY);
        div_case("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, DIV_BUSY);
        div_case("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, DIV_BUSY);
        div_case("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, EARLY_BUSY);
        div_case("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, DIV_BUSY);
        div_case("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, EARLY_BUSY);
        div_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, DIV_BUSY);
        div_case("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, DIV_BUSY);

        // Preload hi=0x11, lo=0x22, then MUL must leave them untouched
        div_case("preload", OP_DIVU, 32'h451, 32'h20, 32'h22, 32'h11, 1'b0, DIV_BUSY);
        issue(OP_MUL, 32'h0001_0003, 32'h0000_0002);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("mul_rv_t%0d", k), bus.result_valid, (k == 5) ? 1 : 0);
            check($sformatf("mul_busy_t%0d", k), bus.busy, (k <= 4) ? 1 : 0);
            if (k == 5) check("mul_result", bus.result, 32'h0002_0006);
            tick();
        end
        check("mul_hi", bus.hi, 32'h11);
        check("mul_lo", bus.lo, 32'h22);

        issue(OP_MUL, 32'hFFFF_FFFD, 32'd5);
        repeat (4) tick();
        check("smul_rv", bus.result_valid, 1);
        check("smul_result", bus.result, 32'hFFFF_FFF1);

        // MFHI / MFLO
        issue(OP_MFHI, 32'd0, 32'd0);
        check("mfhi_rv", bus.result_valid, 1);
        check("mfhi_result", bus.result, 32'h11);
        check("mfhi_busy", bus.busy, 0);
        tick();
        check("mfhi_rv_pulse", bus.result_valid, 0);
        issue(OP_MFLO, 32'd0, 32'd0);
        check("mflo_result", bus.result, 32'h22);

        // MFLO held behind a DIVU
        issue(OP_DIVU, 32'd100, 32'd7);
        bus.start = 1'b1;
        bus.op    = OP_MFLO;
        #1;
        n   = 0;
        bad = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (!bus.stall) bad++;
            tick();
        end
        check("stall_busy_cycles", n, DIV_BUSY);
        check("stall_low_cycles", bad, 0);
        check("stall_released", bus.stall, 0);
        tick();
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        check("stall_mflo_rv", bus.result_valid, 1);
        check("stall_mflo_result", bus.result, 32'd14);

        // Reset in the middle of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_rv", bus.result_valid, 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.result_valid || bus.busy) bad++;
            tick();
        end
        check("midrst_quiet", bad, 0);
        div_case("divu_8_2", OP_DIVU, 32'd8, 32'd2, 32'd4, 32'd0, 1'b0, DIV_BUSY);

        // Divisor larger than dividend
        div_case("divu_3_8", OP_DIVU, 32'd3, 32'd8, 32'd0, 32'd3, 1'b0, EARLY_BUSY);
        div_case("div_m3_8", OP_DIV, 32'hFFFF_FFFD, 32'd8, 32'd0, 32'hFFFF_FFFD, 1'b0, EARLY_BUSY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
